// File: rtl/obstacle_pkg.sv
// Shared types and LFSR step for the falling-obstacle pool.
package obstacle_pkg;
   typedef logic [9:0] coord_t;
   typedef logic [3:0] speed_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      speed_t speed;
      logic   active;
   } obj_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step: feedback bit is the bit shifted out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR supplying spawn position and speed bits.
module lfsr16
   import obstacle_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        advance,
   output logic [15:0] o_state
);
   logic [15:0] r_state;

   always_ff @(posedge Clk) begin
      if (Reset)
         r_state <= SEED;
      else if (advance)
         r_state <= lfsr_next(r_state);
   end

   assign o_state = r_state;
endmodule

// File: rtl/obstacle_pool.sv
// Pool of falling obstacles: periodic pseudo-random spawn, per-frame descent,
// retirement on bottom exit or collision hit.
module obstacle_pool
   import obstacle_pkg::*;
#(
   parameter int          NUM_OBJ        = 4,
   parameter int          OBJ_SIZE       = 20,
   parameter int          X_MIN          = 3,
   parameter int          X_MAX          = 636,
   parameter int          Y_MIN          = 3,
   parameter int          Y_MAX          = 476,
   parameter int          SPAWN_INTERVAL = 60,
   parameter int          MAX_SPEED      = 4,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      frame_tick,
   input  logic                      enable,
   input  logic [NUM_OBJ-1:0]        hit,
   output logic [NUM_OBJ-1:0][9:0]   obj_x,
   output logic [NUM_OBJ-1:0][9:0]   obj_y,
   output logic [NUM_OBJ-1:0][3:0]   obj_speed,
   output logic [NUM_OBJ-1:0]        obj_active,
   output logic [9:0]                object_Size,
   output logic [15:0]               dodged_count,
   output logic                      spawn_missed
);
   localparam int     CNT_W  = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
   localparam int     IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int     EXIT_W = $clog2(NUM_OBJ + 1);
   localparam coord_t Y_EXIT = coord_t'(Y_MAX - OBJ_SIZE);
   localparam coord_t X_LIM  = coord_t'(X_MAX - OBJ_SIZE);
   localparam coord_t Y_INIT = coord_t'(Y_MIN);

   generate
      if (Y_MAX + MAX_SPEED >= 1024) begin : g_bad_width
         $error("obstacle_pool: Y_MAX + MAX_SPEED must be below 1024");
      end
   endgenerate

   obj_t              r_obj [NUM_OBJ];
   obj_t              w_obj_nxt [NUM_OBJ];
   logic [CNT_W-1:0]  r_spawn_cnt;
   logic [15:0]       r_dodged;
   logic              r_missed;

   logic              w_tick;
   logic              w_spawn;
   logic              w_free_found;
   logic [IDX_W-1:0]  w_free_idx;
   logic [EXIT_W-1:0] w_exit_cnt;
   logic [16:0]       w_dodged_sum;
   logic [15:0]       w_r;
   logic [10:0]       w_x_raw;
   coord_t            w_spawn_x;
   speed_t            w_spawn_spd;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .Clk     (Clk),
      .Reset   (Reset),
      .advance (w_tick),
      .o_state (w_r)
   );

   assign w_tick  = frame_tick & enable;
   assign w_spawn = w_tick && (r_spawn_cnt == CNT_W'(SPAWN_INTERVAL - 1));

   assign w_x_raw     = 11'(X_MIN) + {2'b00, w_r[8:0]};
   assign w_spawn_x   = (w_x_raw > {1'b0, X_LIM}) ? X_LIM : w_x_raw[9:0];
   assign w_spawn_spd = ({1'b0, w_r[14:12]} & speed_t'(MAX_SPEED - 1)) + speed_t'(1);

   // Eligibility uses the registered state, so slots freed this cycle wait a tick.
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (!r_obj[i].active) begin
            w_free_found = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_obj_nxt  = r_obj;
      w_exit_cnt = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (hit[i] && r_obj[i].active) begin
            w_obj_nxt[i].active = 1'b0;
         end else if (w_tick && r_obj[i].active) begin
            if (r_obj[i].y > Y_EXIT) begin
               w_obj_nxt[i].active = 1'b0;
               w_exit_cnt          = w_exit_cnt + EXIT_W'(1);
            end else begin
               w_obj_nxt[i].y = r_obj[i].y + coord_t'(r_obj[i].speed);
            end
         end
      end
      // Target was inactive at cycle start, so it never collides with a move.
      if (w_spawn && w_free_found)
         w_obj_nxt[w_free_idx] = '{x: w_spawn_x, y: Y_INIT, speed: w_spawn_spd, active: 1'b1};
   end

   assign w_dodged_sum = {1'b0, r_dodged} + 17'(w_exit_cnt);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_OBJ; i++)
            r_obj[i] <= '{x: '0, y: Y_INIT, speed: '0, active: 1'b0};
         r_spawn_cnt <= '0;
         r_dodged    <= '0;
         r_missed    <= 1'b0;
      end else begin
         r_obj    <= w_obj_nxt;
         r_dodged <= w_dodged_sum[16] ? 16'hFFFF : w_dodged_sum[15:0];
         if (w_spawn && !w_free_found)
            r_missed <= 1'b1;
         if (w_tick)
            r_spawn_cnt <= w_spawn ? '0 : r_spawn_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_OBJ; i++) begin
         obj_x[i]      = r_obj[i].x;
         obj_y[i]      = r_obj[i].y;
         obj_speed[i]  = r_obj[i].speed;
         obj_active[i] = r_obj[i].active;
      end
   end

   assign object_Size  = coord_t'(OBJ_SIZE);
   assign dodged_count = r_dodged;
   assign spawn_missed = r_missed;
endmodule
